tt_um_rx_arq: RTL and testbench

TT_UM_RX_ARQ -- requirements
Module: tt_um_rx_arq

---
 rtl/tt_um_rx_arq.sv | 177 +++++++++++++++++
 tb/tb_tt_um_rx_arq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_rx_arq.sv
// tt_um_rx_arq: stop-and-wait ARQ receiver with a small receive FIFO.
// A frame on ui_in is captured in IDLE, judged in CHECK, and answered with a
// one-cycle ack or nack in RESP. Accepted payloads are queued for the reader.
// Build option: define RX_PARITY_CHECK_EN so that even-parity errors over
// {data,seq} cause a nack. Without it the parity bit is ignored.
module tt_um_rx_arq #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // Even parity: a well-formed frame has XOR of data, seq and parity equal 0.
   function automatic logic parity_err(input logic [DATA_WIDTH-1:0] d,
                                       input logic s, input logic p);
      return ^{d, s, p};
   endfunction

   logic [1:0]            state_r, state_nxt_s;
   logic [DATA_WIDTH-1:0] data_r;
   logic                  seq_r;
   logic                  par_r;
   logic                  exp_seq_r;
   logic [2:0]            err_cnt_r;
   logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  ack_r, nack_r;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   logic frm_valid_s, rd_en_s;
   logic par_err_s, dup_s, full_s, empty_s;
   logic wr_s, rd_s, ack_set_s, nack_set_s;
   logic [2:0] count3_s;
   logic unused_s;

   assign frm_valid_s = ui_in[7];
   assign rd_en_s     = ui_in[6];

   // Frame verdict and FIFO handshakes derived from registered state.
   always_comb begin
      par_err_s  = 1'b0;
      dup_s      = 1'b0;
      wr_s       = 1'b0;
      ack_set_s  = 1'b0;
      nack_set_s = 1'b0;
      full_s     = (count_r == DEPTH_C);
      empty_s    = (count_r == {CW{1'b0}});
      rd_s       = rd_en_s & ~empty_s;
`ifdef RX_PARITY_CHECK_EN
      par_err_s  = parity_err(data_r, seq_r, par_r);
`else
      par_err_s  = 1'b0;
`endif
      if (state_r == ST_CHECK) begin
         dup_s = (seq_r != exp_seq_r);
         if (par_err_s) begin
            nack_set_s = 1'b1;
         end else if (dup_s) begin
            ack_set_s = 1'b1;
         end else if (full_s) begin
            nack_set_s = 1'b1;
         end else begin
            ack_set_s = 1'b1;
            wr_s      = 1'b1;
         end
      end else begin
         dup_s = 1'b0;
      end
   end

   // Next-state logic; frm_valid only matters in IDLE.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (frm_valid_s) begin
               state_nxt_s = ST_CHECK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CHECK: state_nxt_s = ST_RESP;
         ST_RESP:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state, frame capture and the registered ack/nack pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         data_r  <= {DATA_WIDTH{1'b0}};
         seq_r   <= 1'b0;
         par_r   <= 1'b0;
         ack_r   <= 1'b0;
         nack_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && frm_valid_s) begin
            data_r <= ui_in[2 +: DATA_WIDTH];
            seq_r  <= ui_in[1];
            par_r  <= ui_in[0];
         end
         ack_r  <= ack_set_s;
         nack_r <= nack_set_s;
      end
   end

   // Expected sequence bit and saturating error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_seq_r <= 1'b0;
         err_cnt_r <= 3'd0;
      end else begin
         if (wr_s) begin
            exp_seq_r <= ~exp_seq_r;
         end
         if (nack_set_s && (err_cnt_r != 3'd7)) begin
            err_cnt_r <= err_cnt_r + 3'd1;
         end
      end
   end

   // FIFO pointers, occupancy and the read data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (rd_s) begin
            rd_ptr_r  <= rd_ptr_r + AW'(1);
            rd_data_r <= mem_r[rd_ptr_r];
         end
         case ({wr_s, rd_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= data_r;
      end
   end

   assign count3_s = 3'(count_r);
   assign uo_out   = {ack_r, nack_r, 4'(rd_data_r), full_s, empty_s};
   assign uio_out  = {err_cnt_r, count3_s, exp_seq_r, (state_r != ST_IDLE)};
   assign uio_oe   = 8'hFF;
   assign unused_s = &{1'b0, ena, uio_in, par_r};

endmodule

// File: tb/tb_tt_um_rx_arq.sv
// Directed testbench for tt_um_rx_arq with hand-computed expectations.
// Expectations for the parity case follow RX_PARITY_CHECK_EN.
module tb_tt_um_rx_arq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   tt_um_rx_arq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ui_in = 8'h00;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // One frame: sample edge, check edge (optional read), response edge.
   task automatic send(input logic [3:0] d, input logic s, input logic p, input logic rd,
                       input logic exp_ack, input logic exp_nack, input string tag);
      ui_in = {1'b1, 1'b0, d, s, p};
      step();
      ui_in = {1'b0, rd, 4'h0, 2'b00};
      chk({tag, "_busy"}, 8'(uio_out[0]), 8'h01);
      chk({tag, "_pre"}, 8'(uo_out[7:6]), 8'h00);
      step();
      ui_in = 8'h00;
      chk({tag, "_resp"}, 8'(uo_out[7:6]), 8'({exp_ack, exp_nack}));
      step();
      chk({tag, "_post"}, 8'({uo_out[7:6], uio_out[0]}), 8'h00);
   endtask

   task automatic do_read(input logic [3:0] exp_d, input string tag);
      ui_in = 8'h40;
      step();
      ui_in = 8'h00;
      chk(tag, 8'(uo_out[5:2]), 8'(exp_d));
   endtask

   logic par_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      ena    = 1'b1;
      uio_in = 8'h00;
      ui_in  = 8'h00;
      do_reset();

      // Reset state
      chk("rst_uo", uo_out, 8'h01);
      chk("rst_uio", uio_out, 8'h00);
      chk("uio_oe", uio_oe, 8'hFF);

      // Basic accept and read back
      send(4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fa");
      chk("fa_count", 8'(uio_out[4:2]), 8'd1);
      chk("fa_exp", 8'(uio_out[1]), 8'd1);
      chk("fa_empty", 8'(uo_out[0]), 8'd0);
      do_read(4'hA, "fa_rd");
      chk("fa_empty2", 8'(uo_out[0]), 8'd1);

      // Bad parity frame
      do_reset();
`ifdef RX_PARITY_CHECK_EN
      send(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "par");
      chk("par_err", 8'(uio_out[7:5]), 8'd1);
      chk("par_count", 8'(uio_out[4:2]), 8'd0);
      chk("par_exp", 8'(uio_out[1]), 8'd0);
`else
      send(4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "par");
      chk("par_err", 8'(uio_out[7:5]), 8'd0);
      chk("par_count", 8'(uio_out[4:2]), 8'd1);
      chk("par_exp", 8'(uio_out[1]), 8'd1);
`endif

      // Duplicate frame
      do_reset();
      send(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "d1");
      send(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "dup");
      chk("dup_count", 8'(uio_out[4:2]), 8'd1);
      chk("dup_exp", 8'(uio_out[1]), 8'd1);
      chk("dup_err", 8'(uio_out[7:5]), 8'd0);

      // Fill, overflow nack, drain, read while empty
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(4'(i + 1), 1'(i), par_tab[i], 1'b0, 1'b1, 1'b0, "fill");
      end
      chk("full", 8'(uo_out[1]), 8'd1);
      chk("full_count", 8'(uio_out[4:2]), 8'd4);
      send(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovf");
      chk("ovf_err", 8'(uio_out[7:5]), 8'd1);
      chk("ovf_count", 8'(uio_out[4:2]), 8'd4);
      chk("ovf_exp", 8'(uio_out[1]), 8'd0);
      for (int i = 0; i < 4; i++) begin
         do_read(4'(i + 1), "drain");
      end
      chk("drain_empty", 8'(uo_out[0]), 8'd1);
      do_read(4'h4, "rd_empty");
      chk("rd_empty_count", 8'(uio_out[4:2]), 8'd0);

      // Read on the check edge does not rescue a full-FIFO nack
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(4'(i + 1), 1'(i), par_tab[i], 1'b0, 1'b1, 1'b0, "fill2");
      end
      send(4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "ovf_rd");
      chk("ovf_rd_count", 8'(uio_out[4:2]), 8'd3);
      chk("ovf_rd_data", 8'(uo_out[5:2]), 8'h1);
      chk("ovf_rd_err", 8'(uio_out[7:5]), 8'd1);

      // frm_valid held for three cycles gives one frame
      do_reset();
      ui_in = {1'b1, 1'b0, 4'h6, 1'b0, 1'b0};
      step();
      chk("hold_busy", 8'(uio_out[0]), 8'd1);
      step();
      chk("hold_ack", 8'(uo_out[7:6]), 8'h02);
      step();
      chk("hold_idle", 8'({uo_out[7:6], uio_out[0]}), 8'h00);
      ui_in = 8'h00;
      step();
      chk("hold_quiet", 8'({uo_out[7:6], uio_out[0]}), 8'h00);
      chk("hold_count", 8'(uio_out[4:2]), 8'd1);

      // Reset pulse while in CHECK discards the frame
      ui_in = {1'b1, 1'b0, 4'h9, 1'b1, 1'b1};
      step();
      ui_in = 8'h00;
      #1 rst_n = 1'b0;
      #1 chk("arst_uo", uo_out, 8'h01);
      chk("arst_uio", uio_out, 8'h00);
      #1 rst_n = 1'b1;
      step();
      chk("arst_resp", 8'(uo_out[7:6]), 8'h00);
      step();
      chk("arst_count", 8'(uio_out[4:2]), 8'd0);
      chk("arst_busy", 8'(uio_out[0]), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
